// File: rtl/line_draw_pkg.sv
// line_draw_pkg: register map, status bit positions, dispatch states and command sizing
package line_draw_pkg;

  localparam logic [2:0] ADDR_MODE       = 3'd0;
  localparam logic [2:0] ADDR_STATUS     = 3'd1;
  localparam logic [2:0] ADDR_GO         = 3'd2;
  localparam logic [2:0] ADDR_LINE_START = 3'd3;
  localparam logic [2:0] ADDR_LINE_END   = 3'd4;
  localparam logic [2:0] ADDR_COLOUR     = 3'd5;
  localparam logic [2:0] ADDR_CTRL       = 3'd6;
  localparam logic [2:0] ADDR_DONE_CNT   = 3'd7;

  localparam int MODE_POLL   = 0;
  localparam int MODE_IRQ_EN = 1;

  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_CNT  = 8;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_RETIRE} state_t;

  // a queued command is {start point, end point, colour}, each point packed {y, x}
  function automatic int cmd_width(input int x_w, input int y_w, input int colour_w);
    return 2 * (x_w + y_w) + colour_w;
  endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// line_cmd_fifo: synchronous command FIFO with occupancy count
module line_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     i_reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rd_ptr];

  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clock)
    if (wr_en) mem[wr_ptr] <= wdata;

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge i_reset_n)
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

endmodule

// File: rtl/line_draw_cmd_queue.sv
// line_draw_cmd_queue: Avalon-MM register front end queuing line commands for the drawer
module line_draw_cmd_queue
  import line_draw_pkg::*;
#(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3,
  parameter int DEPTH    = 4
) (
  input  logic                clock,
  input  logic                i_reset_n,
  input  logic                i_chipselect,
  input  logic [2:0]          i_address,
  input  logic                i_read,
  input  logic                i_write,
  input  logic [31:0]         i_writedata,
  output logic [31:0]         o_readdata,
  output logic                o_waitrequest,
  input  logic                i_done,
  output logic                o_go,
  output logic [COLOUR_W-1:0] o_colour,
  output logic [X_W-1:0]      o_X0,
  output logic [X_W-1:0]      o_X1,
  output logic [Y_W-1:0]      o_Y0,
  output logic [Y_W-1:0]      o_Y1,
  output logic                o_irq
);

  localparam int PW    = X_W + Y_W;
  localparam int CMD_W = cmd_width(X_W, Y_W, COLOUR_W);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic [1:0]          mode, mode_nxt;
  logic [PW-1:0]       line_start, line_end;
  logic [COLOUR_W-1:0] colour;
  logic                overflow, pending, pending_nxt;
  logic [31:0]         done_cnt;
  state_t              state;
  logic                wr_sel, go_wr, ctrl_clr, cnt_wr, retire, busy;
  logic                full, empty, pop;
  logic [CW-1:0]       count;
  logic [CMD_W-1:0]    head;
  logic                unused_ok;

  assign wr_sel        = i_chipselect & i_write;
  assign go_wr         = wr_sel & (i_address == ADDR_GO);
  assign ctrl_clr      = wr_sel & (i_address == ADDR_CTRL) & i_writedata[0];
  assign cnt_wr        = wr_sel & (i_address == ADDR_DONE_CNT);
  assign retire        = state == S_RETIRE;
  assign pop           = (state == S_IDLE) & ~empty;
  assign busy          = ~empty | (state != S_IDLE);
  assign o_waitrequest = go_wr & full & ~mode[MODE_POLL];
  assign mode_nxt      = wr_sel && i_address == ADDR_MODE ? i_writedata[1:0] : mode;
  assign pending_nxt   = retire | (pending & ~ctrl_clr);
  assign unused_ok     = &{1'b0, i_writedata};

  line_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .i_reset_n (i_reset_n),
    .push      (go_wr),
    .pop       (pop),
    .wdata     ({line_start, line_end, colour}),
    .rdata     (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // software-visible registers, sticky flags, completion counter and interrupt
  always_ff @(posedge clock or negedge i_reset_n)
    if (!i_reset_n) begin
      mode       <= '0;
      line_start <= '0;
      line_end   <= '0;
      colour     <= '0;
      overflow   <= 1'b0;
      pending    <= 1'b0;
      done_cnt   <= '0;
      o_irq      <= 1'b0;
    end else begin
      mode     <= mode_nxt;
      if (wr_sel && i_address == ADDR_LINE_START) line_start <= i_writedata[PW-1:0];
      if (wr_sel && i_address == ADDR_LINE_END)   line_end   <= i_writedata[PW-1:0];
      if (wr_sel && i_address == ADDR_COLOUR)     colour     <= i_writedata[COLOUR_W-1:0];
      overflow <= (overflow & ~ctrl_clr) | (go_wr & full & mode[MODE_POLL]);
      pending  <= pending_nxt;
      done_cnt <= cnt_wr ? 32'(retire) : done_cnt + 32'(retire);
      o_irq    <= pending_nxt & mode_nxt[MODE_IRQ_EN];
    end

  // dispatch: pop a command in idle, hold o_go until done, one retire cycle
  always_ff @(posedge clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state    <= S_IDLE;
      o_go     <= 1'b0;
      o_X0     <= '0;
      o_Y0     <= '0;
      o_X1     <= '0;
      o_Y1     <= '0;
      o_colour <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          {o_Y0, o_X0, o_Y1, o_X1, o_colour} <= head;
          o_go  <= 1'b1;
          state <= S_DRAW;
        end
        S_DRAW: if (i_done) begin
          o_go  <= 1'b0;
          state <= S_RETIRE;
        end
        default: state <= S_IDLE;
      endcase
    end

  // combinational zero-wait register reads
  always_comb begin
    o_readdata = '0;
    if (i_chipselect && i_read)
      case (i_address)
        ADDR_MODE:       o_readdata = 32'(mode);
        ADDR_STATUS:     o_readdata = {16'b0, 8'(count), 5'b0, overflow, full, busy};
        ADDR_LINE_START: o_readdata = 32'(line_start);
        ADDR_LINE_END:   o_readdata = 32'(line_end);
        ADDR_COLOUR:     o_readdata = 32'(colour);
        ADDR_DONE_CNT:   o_readdata = done_cnt;
        default:         o_readdata = '0;
      endcase
  end

endmodule

// File: tb/tb_line_draw_cmd_queue.sv
// tb_line_draw_cmd_queue: directed and randomized checks of the line command queue
module tb_line_draw_cmd_queue;

  localparam int X_W = 9, Y_W = 8, COLOUR_W = 3, DEPTH = 4;

  logic                clock = 1'b0;
  logic                i_reset_n = 1'b0;
  logic                i_chipselect = 1'b0, i_read = 1'b0, i_write = 1'b0, i_done = 1'b0;
  logic [2:0]          i_address = '0;
  logic [31:0]         i_writedata = '0;
  logic [31:0]         o_readdata;
  logic                o_waitrequest, o_go, o_irq;
  logic [COLOUR_W-1:0] o_colour;
  logic [X_W-1:0]      o_X0, o_X1;
  logic [Y_W-1:0]      o_Y0, o_Y1;

  typedef struct {int x0; int y0; int x1; int y1; int c;} line_t;

  int    total = 0, bad = 0, done_model = 0;
  line_t q[$];

  always #5 clock = ~clock;

  line_draw_cmd_queue #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .i_reset_n     (i_reset_n),
    .i_chipselect  (i_chipselect),
    .i_address     (i_address),
    .i_read        (i_read),
    .i_write       (i_write),
    .i_writedata   (i_writedata),
    .o_readdata    (o_readdata),
    .o_waitrequest (o_waitrequest),
    .i_done        (i_done),
    .o_go          (o_go),
    .o_colour      (o_colour),
    .o_X0          (o_X0),
    .o_X1          (o_X1),
    .o_Y0          (o_Y0),
    .o_Y1          (o_Y1),
    .o_irq         (o_irq)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic align;
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    i_chipselect = 1'b1; i_write = 1'b1; i_address = a; i_writedata = d;
    @(negedge clock);
    while (o_waitrequest && n < 200) begin n++; @(negedge clock); end
    if (n == 200) chk("wr_timeout", 64'(o_waitrequest), 0);
    @(posedge clock); #1;
    i_chipselect = 1'b0; i_write = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [2:0] a, input logic [31:0] e);
    logic [31:0] d;
    i_chipselect = 1'b1; i_read = 1'b1; i_address = a;
    @(negedge clock);
    d = o_readdata;
    @(posedge clock); #1;
    i_chipselect = 1'b0; i_read = 1'b0;
    chk(tag, 64'(d), 64'(e));
  endtask

  task automatic wait_go;
    int n = 0;
    @(negedge clock);
    while (!o_go && n < 100) begin n++; @(negedge clock); end
    chk("go_seen", 64'(o_go), 1);
  endtask

  task automatic pulse_done;
    @(posedge clock); #1;
    i_done = 1'b1;
    @(posedge clock); #1;
    i_done = 1'b0;
  endtask

  function automatic logic [63:0] line_exp(input line_t l);
    return 64'({X_W'(l.x0), Y_W'(l.y0), X_W'(l.x1), Y_W'(l.y1), COLOUR_W'(l.c)});
  endfunction

  task automatic push_line(input line_t l);
    wr(3'd3, (l.y0 << X_W) | l.x0);
    wr(3'd4, (l.y1 << X_W) | l.x1);
    wr(3'd5, l.c);
    wr(3'd2, 32'hDEAD_BEEF);
    q.push_back(l);
  endtask

  task automatic drain_one;
    wait_go;
    chk("line", 64'({o_X0, o_Y0, o_X1, o_Y1, o_colour}), line_exp(q[0]));
    q.pop_front();
    repeat ($urandom_range(0, 4)) @(posedge clock);
    pulse_done;
    done_model++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    line_t l;
    logic  go_seen;
    repeat (3) @(posedge clock);
    #2 i_reset_n = 1'b1;
    align;
    for (int a = 0; a < 8; a++) rchk("reset_rd", 3'(a), 0);
    chk("reset_go", 64'(o_go), 0);
    chk("reset_irq", 64'(o_irq), 0);
    chk("reset_wait", 64'(o_waitrequest), 0);

    l = '{5, 7, 10, 100, 3};
    push_line(l);
    rchk("start_rb", 3'd3, 32'h0000_0E05);
    rchk("end_rb", 3'd4, 32'h0000_C80A);
    rchk("colour_rb", 3'd5, 3);
    rchk("go_rd", 3'd2, 0);
    rchk("status_draw", 3'd1, 32'h1);
    drain_one;
    chk("go_low", 64'(o_go), 0);
    align;
    rchk("done1", 3'd7, done_model);

    wr(3'd0, 0);
    fork
      for (int i = 0; i < 6; i++) wr(3'd2, 0);
      begin
        int n = 0;
        @(negedge clock);
        while (!o_waitrequest && n < 100) begin n++; @(negedge clock); end
        chk("stall_wait", 64'(o_waitrequest), 1);
        repeat (5) @(negedge clock);
        chk("stall_hold", 64'(o_waitrequest), 1);
        pulse_done;
      end
    join
    done_model++;
    align;
    rchk("stall_status", 3'd1, 32'h0403);
    for (int i = 0; i < 5; i++) q.push_back(l);
    for (int i = 0; i < 5; i++) drain_one;
    align;
    rchk("stall_done", 3'd7, done_model);

    wr(3'd0, 1);
    wr(3'd7, 0);
    done_model = 0;
    for (int i = 0; i < 6; i++) wr(3'd2, 0);
    for (int i = 0; i < 5; i++) q.push_back(l);
    align;
    rchk("poll_status", 3'd1, 32'h0407);
    for (int i = 0; i < 5; i++) drain_one;
    go_seen = 1'b0;
    repeat (6) begin @(negedge clock); go_seen |= o_go; end
    chk("poll_dropped", 64'(go_seen), 0);
    align;
    rchk("poll_done", 3'd7, done_model);
    wr(3'd6, 1);
    rchk("ovf_clr", 3'd1, 0);

    wr(3'd0, 2);
    push_line('{1, 2, 3, 4, 5});
    drain_one;
    chk("irq_retire", 64'(o_irq), 0);
    align;
    chk("irq_rise", 64'(o_irq), 1);
    wr(3'd6, 1);
    chk("irq_clr", 64'(o_irq), 0);
    push_line('{6, 7, 8, 9, 1});
    drain_one;
    wr(3'd6, 1);
    chk("irq_keep", 64'(o_irq), 1);
    wr(3'd6, 1);
    chk("irq_clr2", 64'(o_irq), 0);
    push_line('{11, 12, 13, 14, 2});
    drain_one;
    wr(3'd7, 32'hFFFF_FFFF);
    align;
    rchk("cnt_same", 3'd7, 1);
    wr(3'd0, 0);

    wr(3'd7, 0);
    done_model = 0;
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) begin
        l = '{int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 7))};
        push_line(l);
      end
      while (q.size() > 0) drain_one;
    end
    repeat (3) align;
    rchk("rand_done", 3'd7, done_model);
    rchk("rand_status", 3'd1, 0);

    for (int i = 0; i < 4; i++) wr(3'd2, 0);
    wait_go;
    #2 i_reset_n = 1'b0;
    #1 chk("rst_go", 64'(o_go), 0);
    repeat (2) @(negedge clock);
    i_reset_n = 1'b1;
    align;
    rchk("rst_status", 3'd1, 0);
    rchk("rst_cnt", 3'd7, 0);
    go_seen = 1'b0;
    repeat (10) begin @(negedge clock); go_seen |= o_go; end
    chk("rst_nogo", 64'(go_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
